// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM memory responder: MMIO register offsets,
// responder states and the default MMIO window base.
package arm_mem_pkg;

    localparam logic [3:0] OFF_GPIO = 4'h0;
    localparam logic [3:0] OFF_CYC  = 4'h4;
    localparam logic [3:0] OFF_HALT = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_FF00;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

endpackage

// File: rtl/mem_ram.sv
// Word-addressed RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module mem_ram #(
    parameter int unsigned MemWords = 64,
    parameter int unsigned Aw       = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [Aw-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MemWords];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the multicycle ARM core: RAM, small MMIO window,
// and a boot loader that fills RAM while the core is held in reset.
module arm_mem_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned AW        = 6,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [31:0]   Adr,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          core_hold,
    output logic [31:0]   gpio_out,
    output logic          halt,
    output logic          err
);

    state_e      state_q, state_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cyc_q, cyc_d;
    logic        err_q, err_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic       in_ram, in_io;
    logic [3:0] io_off;
    logic       unused_adr;

    assign unused_adr = ^Adr[1:0];
    assign in_ram     = (Adr[31:AW+2] == '0);
    assign in_io      = (Adr[31:4] == IO_BASE[31:4]);
    assign io_off     = {Adr[3:2], 2'b00};

    mem_ram #(
        .MemWords (MEM_WORDS),
        .Aw       (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (Adr[AW+1:2]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLoad;
            gpio_q  <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gpio_q  <= gpio_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    // RAM writes are gated by reset so an edge during reset leaves no partial effect.
    always_comb begin
        state_d   = state_q;
        gpio_d    = gpio_q;
        cyc_d     = cyc_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = Adr[AW+1:2];
        ram_wdata = WriteData;
        unique case (state_q)
            StLoad: begin
                ram_waddr = ld_addr;
                ram_wdata = ld_data;
                if (ld_valid && reset) begin
                    ram_we = 1'b1;
                    if (ld_last) state_d = StRun;
                end
            end
            StRun: begin
                cyc_d = cyc_q + 32'd1;
                if (MemWrite) begin
                    if (in_ram) begin
                        ram_we = reset;
                    end else if (in_io) begin
                        if (io_off == OFF_GPIO) gpio_d = WriteData;
                        if (io_off == OFF_HALT && WriteData != '0) state_d = StHalted;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHalted: begin
                if (MemWrite && !in_ram && !in_io) err_d = 1'b1;
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        ReadData = '0;
        if (state_q != StLoad) begin
            if (in_ram) begin
                ReadData = ram_rdata;
            end else if (in_io) begin
                case (io_off)
                    OFF_GPIO: ReadData = gpio_q;
                    OFF_CYC:  ReadData = cyc_q;
                    OFF_STAT: ReadData = {30'b0, err_q, state_q == StHalted};
                    default:  ReadData = '0;
                endcase
            end
        end
    end

    assign ld_ready  = (state_q == StLoad);
    assign core_hold = (state_q == StLoad);
    assign halt      = (state_q == StHalted);
    assign gpio_out  = gpio_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed + randomized bench for arm_mem_responder against a behavioural model
// of the memory map (mode, RAM image, GPIO, cycle count, sticky error).
module tb_arm_mem_responder;

    localparam int          MEM_WORDS = 64;
    localparam int          AW        = 6;
    localparam logic [31:0] IO_BASE   = 32'h0000_FF00;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          MemWrite  = 1'b0;
    logic [31:0]   Adr       = '0;
    logic [31:0]   WriteData = '0;
    logic [31:0]   ReadData;
    logic          ld_valid  = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr   = '0;
    logic [31:0]   ld_data   = '0;
    logic          ld_last   = 1'b0;
    logic          core_hold;
    logic [31:0]   gpio_out;
    logic          halt;
    logic          err;

    arm_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW),
        .IO_BASE   (IO_BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .core_hold (core_hold),
        .gpio_out  (gpio_out),
        .halt      (halt),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = loading, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_mem [MEM_WORDS];
    logic [31:0] m_gpio;
    logic [31:0] m_cyc;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] boot [4];
    logic [31:0] c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_gpio = '0;
        m_cyc  = '0;
        m_err  = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (m_mode == 0) return '0;
        if (a < MEM_WORDS * 4) return m_mem[int'(a >> 2)];
        if (a >= IO_BASE && a < IO_BASE + 16) begin
            case (int'((a - IO_BASE) >> 2))
                0:       return m_gpio;
                1:       return m_cyc;
                3:       return {30'b0, m_err, m_mode == 2};
                default: return '0;
            endcase
        end
        return '0;
    endfunction

    task automatic m_tick();
        logic in_ram;
        logic in_io;
        int   off;
        in_ram = (Adr < MEM_WORDS * 4);
        in_io  = (Adr >= IO_BASE && Adr < IO_BASE + 16);
        off    = int'((Adr - IO_BASE) & 32'hC);
        if (m_mode == 0) begin
            if (ld_valid) begin
                m_mem[ld_addr] = ld_data;
                if (ld_last) m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_cyc = m_cyc + 1;
            if (MemWrite) begin
                if (in_ram) m_mem[int'(Adr >> 2)] = WriteData;
                else if (in_io) begin
                    if (off == 0) m_gpio = WriteData;
                    if (off == 8 && WriteData != 0) m_mode = 2;
                end else m_err = 1'b1;
            end
        end else begin
            if (MemWrite && !in_ram && !in_io) m_err = 1'b1;
        end
    endtask

    // Called at a negedge with inputs set: check outputs, advance model and DUT one cycle.
    task automatic step(input string tag);
        logic [31:0] exp_rd;
        #1;
        exp_rd = m_read(Adr);
        if (!$isunknown(exp_rd)) chk({tag, ":rd"}, ReadData, exp_rd);
        chk({tag, ":ctl"}, {28'b0, ld_ready, core_hold, halt, err},
            {28'b0, m_mode == 0, m_mode == 0, m_mode == 2, m_err});
        chk({tag, ":gpio"}, gpio_out, m_gpio);
        if (reset) m_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        MemWrite  = wr;
        Adr       = a;
        WriteData = d;
        step(tag);
        MemWrite  = 1'b0;
    endtask

    task automatic rd_expect(input logic [31:0] a, input logic [31:0] exp, input string tag);
        MemWrite = 1'b0;
        Adr      = a;
        #1;
        chk(tag, ReadData, exp);
        step(tag);
    endtask

    task automatic ld(input int addr, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = addr[AW-1:0];
        ld_data  = d;
        ld_last  = last;
        step("load");
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        boot[0] = 32'hE3A0_0005;
        boot[1] = 32'hE3A0_1007;
        boot[2] = 32'hE081_2000;
        boot[3] = 32'hE580_2064;
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 'x;
        m_reset();

        // Reset held for three cycles
        @(negedge clk);
        repeat (3) step("reset");
        reset = 1'b1;

        // Boot load: random image above the program, then the program with ld_last
        for (int i = 4; i < MEM_WORDS; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                MemWrite = 1'($urandom);
                Adr      = $urandom_range(0, 255);
                step("ld_gap");
            end
            ld(i, $urandom, 1'b0);
        end
        MemWrite = 1'b0;
        for (int i = 0; i < 4; i++) ld(i, boot[i], i == 3);
        #1;
        chk("core_hold_fall", {31'b0, core_hold}, 32'd0);
        for (int i = 0; i < 4; i++) rd_expect(32'(i * 4), boot[i], "boot_rd");

        // Random traffic in RUN; loader inputs toggle and must be ignored
        for (int i = 0; i < 150; i++) begin
            int r;
            r         = $urandom_range(0, 3);
            ld_valid  = 1'($urandom);
            ld_addr   = AW'($urandom);
            ld_data   = $urandom;
            ld_last   = 1'($urandom);
            WriteData = $urandom;
            MemWrite  = 1'($urandom);
            case (r)
                1: begin
                    c0  = 32'($urandom_range(0, 2));
                    Adr = IO_BASE + (c0 == 2 ? 32'hC : c0 * 4) + 32'($urandom_range(0, 3));
                end
                2: begin
                    Adr      = 32'h0001_0000 | $urandom;
                    MemWrite = 1'b0;
                end
                default: Adr = $urandom_range(16, 255);
            endcase
            step("rand");
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        MemWrite = 1'b0;

        // RAM write/read: same-cycle old data, next-cycle new data
        cpu(1'b1, 32'h64, 32'hDEAD_BEEF, "ram_wr");
        rd_expect(32'h64, 32'hDEAD_BEEF, "ram_rd_new");

        // MMIO: GPIO, CYCLES step, write to CYCLES dropped
        cpu(1'b1, IO_BASE, 32'hA5, "gpio_wr");
        rd_expect(IO_BASE, 32'hA5, "gpio_rd");
        chk("gpio_out", gpio_out, 32'hA5);
        c0 = m_cyc;
        rd_expect(IO_BASE + 4, c0, "cyc_a");
        repeat (4) step("cyc_wait");
        rd_expect(IO_BASE + 4, c0 + 5, "cyc_b");
        cpu(1'b1, IO_BASE + 4, 32'h1, "cyc_wr");
        rd_expect(IO_BASE + 4, c0 + 7, "cyc_ro");
        cpu(1'b1, IO_BASE + 8, 32'h0, "halt_zero");
        chk("halt_zero_flag", {31'b0, halt}, 32'd0);
        rd_expect(IO_BASE + 8, 32'h0, "halt_rd");

        // Out-of-range write sets err; read of that address returns 0
        rd_expect(IO_BASE + 12, 32'h0, "stat_clean");
        cpu(1'b1, 32'h8000, 32'h1234, "oor_wr");
        chk("err_set", {31'b0, err}, 32'd1);
        rd_expect(32'h8000, 32'h0, "oor_rd");
        rd_expect(IO_BASE + 12, 32'h2, "stat_err");

        // CYCLES wrap
        Adr = IO_BASE + 4;
        force dut.cyc_q = 32'hFFFF_FFFE;
        m_cyc = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_q;
        step("wrap_fe");
        step("wrap_ff");
        rd_expect(IO_BASE + 4, 32'h0, "wrap_zero");

        // Halt: later writes dropped, reads still served, CYCLES frozen
        cpu(1'b1, IO_BASE + 8, 32'h1, "halt_wr");
        chk("halt_flag", {31'b0, halt}, 32'd1);
        cpu(1'b1, IO_BASE, 32'h3C, "halted_gpio_wr");
        cpu(1'b1, 32'h0, 32'h7, "halted_ram_wr");
        rd_expect(IO_BASE, 32'hA5, "halted_gpio_rd");
        rd_expect(32'h0, boot[0], "halted_ram_rd");
        rd_expect(IO_BASE + 12, 32'h3, "halted_stat");
        c0 = m_cyc;
        rd_expect(IO_BASE + 4, c0, "frozen_a");
        repeat (3) step("frozen_wait");
        rd_expect(IO_BASE + 4, c0, "frozen_b");

        // Reset from HALTED, then reset again mid-load with a word pending
        reset = 1'b0;
        m_reset();
        #1;
        chk("rst_async_ctl", {28'b0, ld_ready, core_hold, halt, err}, 32'hC);
        chk("rst_async_gpio", gpio_out, 32'h0);
        step("rst6");
        reset = 1'b1;
        step("rst6_rel");
        ld(0, 32'h1111_1111, 1'b0);
        ld(1, 32'h2222_2222, 1'b0);
        ld_valid = 1'b1;
        ld_addr  = 2;
        ld_data  = 32'h3333_3333;
        reset    = 1'b0;
        m_reset();
        #1;
        chk("midload_ctl", {28'b0, ld_ready, core_hold, halt, err}, 32'hC);
        step("midload_rst");
        step("midload_rst");
        ld_valid = 1'b0;
        reset    = 1'b1;
        step("midload_rel");
        ld(5, 32'h5555_5555, 1'b1);
        rd_expect(32'h4, 32'h2222_2222, "word1_kept");
        rd_expect(32'h8, boot[2], "word2_untouched");
        rd_expect(32'h0, 32'h1111_1111, "word0_new");
        rd_expect(IO_BASE + 12, 32'h0, "stat_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
